// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces three coin sensors and emits one registered pulse per accepted or refused coin; ports clk/rst, raw_ten/raw_twenty/raw_fifty/enable in, ten/twenty/fifty/reject/busy out
module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_ten,
  input  logic raw_twenty,
  input  logic raw_fifty,
  input  logic enable,
  output logic ten,
  output logic twenty,
  output logic fifty,
  output logic reject,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, EMIT, REJECT, RELEASE} state_t;
  localparam logic [CNT_WIDTH:0] LIMIT = (CNT_WIDTH+1)'(DEBOUNCE_CYCLES);
  state_t state, state_nxt;
  logic [2:0] sync1, s, coin, coin_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt, cnt_sat;
  logic [CNT_WIDTH:0] cnt_inc;
  logic any_s, single_s, done;
  assign any_s = |s;
  assign single_s = any_s && ((s & (s - 3'd1)) == 3'd0);
  assign cnt_inc = {1'b0, cnt} + (CNT_WIDTH+1)'(1);
  assign done = cnt_inc >= LIMIT;
  assign cnt_sat = done ? LIMIT[CNT_WIDTH-1:0] : cnt_inc[CNT_WIDTH-1:0];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1 <= '0;
      s <= '0;
      state <= IDLE;
      cnt <= '0;
      coin <= '0;
      {ten, twenty, fifty, reject, busy} <= '0;
    end else begin
      sync1 <= {raw_fifty, raw_twenty, raw_ten};
      s <= sync1;
      state <= state_nxt;
      cnt <= cnt_nxt;
      coin <= coin_nxt;
      ten <= state_nxt == EMIT && coin_nxt[0];
      twenty <= state_nxt == EMIT && coin_nxt[1];
      fifty <= state_nxt == EMIT && coin_nxt[2];
      reject <= state_nxt == REJECT;
      busy <= state_nxt != IDLE;
    end
  // The transition into EMIT happens on the edge that makes the count reach
  // DEBOUNCE_CYCLES, so the registered pulse appears together with EMIT.
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    coin_nxt = coin;
    case (state)
      IDLE:
        if (any_s) begin
          state_nxt = single_s && enable ? DEBOUNCE : REJECT;
          coin_nxt = single_s && enable ? s : coin;
          cnt_nxt = single_s && enable ? CNT_WIDTH'(1) : '0;
        end
      DEBOUNCE: begin
        state_nxt = |(s & ~coin) ? REJECT : !(|(s & coin)) ? IDLE : done ? EMIT : DEBOUNCE;
        cnt_nxt = state_nxt == DEBOUNCE ? cnt_sat : '0;
      end
      EMIT, REJECT: begin
        state_nxt = RELEASE;
        cnt_nxt = '0;
      end
      RELEASE: begin
        state_nxt = !any_s && done ? IDLE : RELEASE;
        cnt_nxt = any_s || done ? '0 : cnt_sat;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized and directed checks of coin_acceptor against a behavioural coin model
`timescale 1ns/1ps
module tb_coin_acceptor;
  localparam int D = 4;
  logic clk = 0, rst = 1, raw_ten = 0, raw_twenty = 0, raw_fifty = 0, enable = 1;
  logic ten, twenty, fifty, reject, busy;
  int total = 0, bad = 0;
  bit chk_en = 0;
  coin_acceptor #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .raw_ten(raw_ten), .raw_twenty(raw_twenty), .raw_fifty(raw_fifty),
    .enable(enable), .ten(ten), .twenty(twenty), .fifty(fifty), .reject(reject), .busy(busy)
  );
  always #25 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask
  logic [2:0] m_s1, m_s2;
  int m_coin, m_run, m_quiet;
  bit m_emit, m_hold;
  logic [3:0] e_p;
  logic e_busy;
  always @(posedge clk or posedge rst) begin : mdl
    int n;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_coin = -1; m_run = 0; m_quiet = 0;
      m_emit = 0; m_hold = 0; e_p = 0; e_busy = 0;
    end else begin
      n = $countones(m_s2);
      e_p = 0;
      if (m_emit) begin
        m_emit = 0; m_hold = 1; m_quiet = 0;
      end else if (m_hold) begin
        if (n > 0) m_quiet = 0;
        else begin
          m_quiet++;
          if (m_quiet == D) m_hold = 0;
        end
      end else if (m_coin >= 0) begin
        if (n > int'(m_s2[m_coin])) begin
          m_coin = -1; m_emit = 1; e_p[3] = 1;
        end else if (!m_s2[m_coin]) m_coin = -1;
        else begin
          m_run++;
          if (m_run == D) begin
            e_p[m_coin] = 1; m_emit = 1; m_coin = -1;
          end
        end
      end else if (n > 0) begin
        if (n == 1 && enable) begin
          m_coin = m_s2[0] ? 0 : m_s2[1] ? 1 : 2;
          m_run = 1;
        end else begin
          m_emit = 1; e_p[3] = 1;
        end
      end
      e_busy = m_coin >= 0 || m_emit || m_hold;
      m_s2 = m_s1;
      m_s1 = {raw_fifty, raw_twenty, raw_ten};
    end
  end
  always @(negedge clk)
    if (chk_en) begin
      check("ten", ten, e_p[0]);
      check("twenty", twenty, e_p[1]);
      check("fifty", fifty, e_p[2]);
      check("reject", reject, e_p[3]);
      check("busy", busy, e_busy);
      check("onehot", (32'(ten) + twenty + fifty + reject) <= 1, 1);
    end
  int pc[4], pf[4], bl, kk;
  int order[$];
  task automatic clr();
    pc = '{default: 0};
    pf = '{default: -1};
    bl = -1;
    kk = 0;
    order.delete();
  endtask
  task automatic watch(input int n);
    logic [3:0] p;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      p = {reject, fifty, twenty, ten};
      for (int j = 0; j < 4; j++)
        if (p[j]) begin
          pc[j]++;
          if (pf[j] < 0) pf[j] = kk;
          if (j < 3) order.push_back(j);
        end
      if (!busy && bl < 0) bl = kk;
      kk++;
    end
  endtask
  initial begin
    int hold[3];
    logic [2:0] lvl;
    #1;
    check("rst_outs", {ten, twenty, fifty, reject, busy}, 0);
    @(negedge clk); @(negedge clk);
    rst = 0;
    chk_en = 1;
    clr(); raw_ten = 1; watch(10);
    check("l_ten_first", pf[0], 5);
    check("l_ten_count", pc[0], 1);
    check("l_ten_other", pc[1] + pc[2] + pc[3], 0);
    raw_ten = 0; clr(); watch(8);
    check("l_ten_again", pc[0], 0);
    check("l_busy_low", bl, 5);
    clr(); raw_twenty = 1; watch(2); raw_twenty = 0; watch(10);
    check("glitch_twenty", pc[1], 0);
    check("glitch_reject", pc[3], 0);
    check("glitch_idle", busy, 0);
    clr(); raw_ten = 1; raw_fifty = 1; watch(6);
    check("dual_reject", pc[3], 1);
    check("dual_coins", pc[0] + pc[2], 0);
    check("dual_busy", busy, 1);
    raw_ten = 0; raw_fifty = 0; watch(8);
    check("dual_idle", busy, 0);
    check("dual_reject_total", pc[3], 1);
    clr(); enable = 0; raw_fifty = 1; watch(10);
    check("dis_reject", pc[3], 1);
    check("dis_fifty", pc[2], 0);
    raw_fifty = 0; watch(8); enable = 1;
    clr(); raw_twenty = 1; watch(4);
    check("pre_rst_busy", busy, 1);
    #5 rst = 1;
    #0.5;
    check("async_rst_outs", {ten, twenty, fifty, reject, busy}, 0);
    #0.5 rst = 0;
    clr(); watch(10);
    check("rst_twenty_first", pf[1], 5);
    check("rst_twenty_count", pc[1], 1);
    raw_twenty = 0; watch(8);
    clr();
    for (int i = 0; i < 3; i++) begin
      {raw_fifty, raw_twenty, raw_ten} = 3'(1 << i);
      watch(8);
      {raw_fifty, raw_twenty, raw_ten} = 0;
      watch(6);
    end
    check("seq_ten", pc[0], 1);
    check("seq_twenty", pc[1], 1);
    check("seq_fifty", pc[2], 1);
    check("seq_reject", pc[3], 0);
    check("seq_len", order.size(), 3);
    for (int i = 0; i < 3 && i < order.size(); i++) check("seq_order", order[i], i);
    hold = '{default: 0};
    lvl = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
        if (hold[j] == 0) begin
          lvl[j] = $urandom_range(0, 3) == 0;
          hold[j] = lvl[j] ? $urandom_range(1, 12) : $urandom_range(1, 20);
        end
        hold[j]--;
      end
      {raw_fifty, raw_twenty, raw_ten} = lvl;
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 399) == 0) begin
        #($urandom_range(1, 20)) rst = 1;
        #1 rst = 0;
      end
    end
    {raw_fifty, raw_twenty, raw_ten} = 0;
    repeat (12) @(negedge clk);
    check("final_idle", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
